// File: rtl/wb_traffic_gen.sv
// Wishbone classic traffic generator. Runs LFSR-addressed write/readback (or
// read-only) transactions against one slave window and tallies pass/fail/timeout.
module wb_traffic_gen #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 16,
    parameter int          OFFSET_BITS = 12,
    parameter int          NUM_TXN     = 100,
    parameter int          TIMEOUT     = 15,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                mode_i,
    input  logic [ADDR_WIDTH-OFFSET_BITS-1:0]   win_i,
    input  logic [DATA_WIDTH-1:0]               exp_i,
    output logic [ADDR_WIDTH-1:0]               adr_o,
    output logic [DATA_WIDTH-1:0]               dat_o,
    output logic                                we_o,
    output logic                                cyc_o,
    output logic                                stb_o,
    input  logic [DATA_WIDTH-1:0]               dat_i,
    input  logic                                ack_i,
    input  logic                                err_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [$clog2(NUM_TXN+1)-1:0]        pass_cnt_o,
    output logic [$clog2(NUM_TXN+1)-1:0]        fail_cnt_o,
    output logic [$clog2(NUM_TXN+1)-1:0]        tmo_cnt_o
);

    localparam int          WIN_W     = ADDR_WIDTH - OFFSET_BITS;
    localparam int          CNT_W     = $clog2(NUM_TXN + 1);
    localparam int          WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(NUM_TXN);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_TXN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    // S_TURN is the one idle bus cycle between a write and its readback.
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_TURN, S_READ, S_CHECK, S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_mode;
    logic [WIN_W-1:0]        r_win;
    logic [DATA_WIDTH-1:0]   r_exp;
    logic [31:0]             r_addr_lfsr;
    logic [31:0]             r_data_lfsr;
    logic [WAIT_W-1:0]       r_wait;
    logic [CNT_W-1:0]        r_txn_idx;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    r_err;
    logic                    r_tmo;
    logic [CNT_W-1:0]        r_pass;
    logic [CNT_W-1:0]        r_fail;
    logic [CNT_W-1:0]        r_tmo_cnt;

    logic                    w_in_access;
    logic                    w_timeout;
    logic [OFFSET_BITS-1:0]  w_offset;
    logic [ADDR_WIDTH-1:0]   w_adr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [DATA_WIDTH-1:0]   w_ref;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    assign w_in_access = (r_state == S_WRITE) || (r_state == S_READ);
    assign w_timeout   = (r_wait == WAIT_LAST) && !ack_i && !err_i;
    assign w_offset    = OFFSET_BITS'(r_addr_lfsr);
    assign w_adr       = {r_win, w_offset};
    assign w_wr_data   = DATA_WIDTH'(r_data_lfsr);
    assign w_ref       = r_mode ? r_exp : w_wr_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no branch can infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next_state = mode_i ? S_READ : S_WRITE;
            S_WRITE: begin
                if (err_i || w_timeout) w_next_state = S_CHECK;
                else if (ack_i)         w_next_state = S_TURN;
            end
            S_TURN:  w_next_state = S_READ;
            S_READ:  if (err_i || ack_i || w_timeout) w_next_state = S_CHECK;
            S_CHECK: begin
                if (r_txn_idx == LAST_IDX) w_next_state = S_DONE;
                else                       w_next_state = r_mode ? S_READ : S_WRITE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        we_o   = 1'b0;
        adr_o  = '0;
        dat_o  = '0;
        done_o = 1'b0;
        busy_o = (r_state != S_IDLE);
        case (r_state)
            S_WRITE: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = 1'b1;
                adr_o = w_adr;
                dat_o = w_wr_data;
            end
            S_READ: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                adr_o = w_adr;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath: error/timeout flags are tallied in CHECK so each transaction
    // bumps exactly one of pass/fail.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode      <= 1'b0;
            r_win       <= '0;
            r_exp       <= '0;
            r_addr_lfsr <= LFSR_INIT;
            r_data_lfsr <= LFSR_INIT;
            r_wait      <= '0;
            r_txn_idx   <= '0;
            r_rd_data   <= '0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_tmo_cnt   <= '0;
        end else begin
            // NOTE: non-blocking everywhere here; every read sees pre-edge state.
            if (w_in_access && (w_next_state == r_state)) r_wait <= r_wait + WAIT_W'(1);
            else                                          r_wait <= '0;

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mode    <= mode_i;
                        r_win     <= win_i;
                        r_exp     <= exp_i;
                        r_txn_idx <= '0;
                        r_err     <= 1'b0;
                        r_tmo     <= 1'b0;
                        r_pass    <= '0;
                        r_fail    <= '0;
                        r_tmo_cnt <= '0;
                    end
                end
                S_WRITE, S_READ: begin
                    if (err_i)                          r_err     <= 1'b1;
                    else if (ack_i && r_state == S_READ) r_rd_data <= dat_i;
                    else if (w_timeout)                 r_tmo     <= 1'b1;
                end
                S_CHECK: begin
                    if (r_tmo) begin
                        r_fail    <= sat_inc(r_fail);
                        r_tmo_cnt <= sat_inc(r_tmo_cnt);
                    end else if (r_err || (r_rd_data != w_ref)) begin
                        r_fail <= sat_inc(r_fail);
                    end else begin
                        r_pass <= sat_inc(r_pass);
                    end
                    r_err       <= 1'b0;
                    r_tmo       <= 1'b0;
                    r_addr_lfsr <= lfsr_next(r_addr_lfsr);
                    r_data_lfsr <= lfsr_next(r_data_lfsr);
                    if (r_txn_idx != LAST_IDX) r_txn_idx <= r_txn_idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign pass_cnt_o = r_pass;
    assign fail_cnt_o = r_fail;
    assign tmo_cnt_o  = r_tmo_cnt;

endmodule

// File: doc/wb_traffic_gen.md
WB_TRAFFIC_GEN -- requirements
Module: wb_traffic_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: Wishbone data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: Wishbone address width.
REQ-003 SHALL have parameter OFFSET_BITS, default 12: in-window offset width; upper ADDR_WIDTH-OFFSET_BITS bits select the slave.
REQ-004 SHALL have parameter NUM_TXN, default 100: transactions per run.
REQ-005 SHALL have parameter TIMEOUT, default 15: maximum cycles with stb_o high and no ack_i/err_i.
REQ-006 SHALL have parameter SEED, default 32'h1: LFSR seed; a value of 0 is replaced by 1.
REQ-007 SHALL have port clk_i, input, 1: the only clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port start_i, input, 1: run request pulse.
REQ-010 SHALL have port mode_i, input, 1: 0 = write then readback compare; 1 = read-only compare against exp_i.
REQ-011 SHALL have port win_i, input, ADDR_WIDTH-OFFSET_BITS: target slave window.
REQ-012 SHALL have port exp_i, input, DATA_WIDTH: expected read data in mode 1.
REQ-013 SHALL have ports adr_o (ADDR_WIDTH), dat_o (DATA_WIDTH), we_o, cyc_o, stb_o (1 each), all outputs: Wishbone classic master outputs.
REQ-014 SHALL have ports dat_i (DATA_WIDTH), ack_i, err_i (1 each), all inputs: Wishbone classic master inputs.
REQ-015 SHALL have port busy_o, output, 1: run in progress.
REQ-016 SHALL have port done_o, output, 1: one-cycle end-of-run pulse.
REQ-017 SHALL have ports pass_cnt_o, fail_cnt_o, tmo_cnt_o, outputs, $clog2(NUM_TXN+1) each: result counters.

Function
REQ-018 SHALL implement states IDLE, WRITE, READ, CHECK, DONE.
REQ-019 SHALL, in IDLE when start_i=1, latch mode_i, win_i and exp_i, clear all three counters, and enter WRITE on the next cycle (mode 0) or READ (mode 1).
REQ-020 SHALL ignore start_i in every state other than IDLE.
REQ-021 SHALL drive adr_o = {win, addr_lfsr[OFFSET_BITS-1:0]}, and in WRITE dat_o = data_lfsr, we_o=1; in READ we_o=0.
REQ-022 SHALL hold cyc_o=stb_o=1 and adr_o/dat_o/we_o stable for every cycle in WRITE/READ, and drive cyc_o=stb_o=0 in all other states.
REQ-023 SHALL, in WRITE, go to READ on the cycle after ack_i=1, keeping the same address; the two accesses are separated by one cycle with cyc_o=0.
REQ-024 SHALL, in READ, capture dat_i on the ack_i=1 cycle and go to CHECK.
REQ-025 SHALL, in CHECK, count pass when the captured data equals the reference (the written data_lfsr in mode 0, exp_i in mode 1), and otherwise count fail.
REQ-026 SHALL treat err_i=1 in WRITE or READ as terminating that transaction: go to CHECK and count fail, skipping the read in mode 0.
REQ-027 SHALL treat ack_i and err_i both high as err_i.
REQ-028 SHALL keep a wait counter that clears on entry to WRITE/READ; if TIMEOUT cycles elapse with no ack_i/err_i, it SHALL drop cyc_o/stb_o, increment fail_cnt_o and tmo_cnt_o, and go to CHECK with no further compare.
REQ-029 SHALL increment exactly one of pass/fail per transaction; tmo_cnt_o is a subset of fail_cnt_o.
REQ-030 SHALL, on leaving CHECK, advance both LFSRs one step (32-bit Galois, x^32+x^22+x^2+x+1).
REQ-031 SHALL, on leaving CHECK, go to DONE when the transaction index equals NUM_TXN-1, and otherwise start the next transaction.
REQ-032 SHALL, in DONE, assert done_o for exactly one cycle and then return to IDLE; counters hold until the next start.
REQ-033 SHALL drive busy_o=1 in every state except IDLE.
REQ-034 SHALL saturate counters at NUM_TXN and SHALL NOT wrap them.

Reset
REQ-035 SHALL, when rst_i=1 at a clock edge (including mid-transaction), enter IDLE, drive cyc_o=stb_o=we_o=busy_o=done_o=0 and adr_o=dat_o=0, clear all counters and the transaction index, and reload both LFSRs with SEED.
REQ-036 SHALL NOT complete an interrupted transaction, and SHALL NOT count it, after reset is released.

Verification
REQ-037 Reset: rst_i=1 for 2 cycles -> all outputs 0 and state IDLE; the first adr_o after start equals {win, SEED[11:0]}.
REQ-038 Mode 0, win=2, 4096x32 register-file slave with 1-cycle ack, NUM_TXN=100 -> pass=100, fail=0, tmo=0, one done_o pulse, every read address equals the preceding write address.
REQ-039 Mode 1, win=0, slave returning 32'hAAAA0000, exp_i=32'hAAAA0000 -> pass=100; rerun with exp_i=32'hBBBB0000 -> fail=100.
REQ-040 Slave never acks, TIMEOUT=15 -> each transaction has stb_o high for exactly 15 cycles; fail=tmo=100, no read issued.
REQ-041 err_i on the read of transaction 7 only -> pass=99, fail=1, tmo=0.
REQ-042 rst_i pulsed during WRITE of transaction 3 -> cyc_o=0 at the next edge, counters 0, start_i ignored while busy and accepted afterwards.
